tara_ctrl: RTL

//   Parametrised tare unit for the scale datapath. Holds a tare register (reset
//   to a fixed cable-tare constant), acquires a new tare on request by averaging
//   2**AVG_LOG2 valid gross samples, and outputs a registered, saturating net

---
 rtl/tara_ctrl_if.sv | 29 ++
 rtl/tara_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/tara_ctrl_if.sv
// Tare unit bus: gross samples and tare commands in, tare/net status out.
// Latency: n/a (signal bundle only).
// Backpressure: none; gross_valid is a plain strobe with no ready.
interface tara_ctrl_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] gross;
  logic             gross_valid;
  logic             tare_req;
  logic             tare_clr;
  logic [WIDTH-1:0] tare;
  logic [WIDTH-1:0] net;
  logic             net_valid;
  logic             underflow;
  logic             busy;
  logic             tare_done;

  // Driver side: the sampler/controller feeding the tare unit
  modport master (
    output gross, gross_valid, tare_req, tare_clr,
    input  tare, net, net_valid, underflow, busy, tare_done
  );

  // Tare unit side
  modport slave (
    input  gross, gross_valid, tare_req, tare_clr,
    output tare, net, net_valid, underflow, busy, tare_done
  );
endinterface

// File: rtl/tara_ctrl.sv
// Tare register with averaged acquisition and saturating registered net = gross - tare.
// Latency: net one cycle after gross_valid; tare commits one cycle after the last averaged sample.
// Backpressure: none; samples are always accepted, gaps in gross_valid just stall acquisition.
module tara_ctrl #(
  parameter int WIDTH        = 12,
  parameter int DEFAULT_TARE = 40,
  parameter int AVG_LOG2     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  tara_ctrl_if.slave   bus
);

  localparam int ACC_W = WIDTH + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [WIDTH-1:0] TARE_RST = WIDTH'(DEFAULT_TARE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  tare_q, tare_d;
  logic [WIDTH-1:0]  net_q, net_d;
  logic              net_valid_q, net_valid_d;
  logic              underflow_q, underflow_d;
  logic              busy_o_c;
  logic              tare_done_o_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; tare_clr overrides everything, including a pending commit
  always_comb begin
    state_d = state_q;
    if (bus.tare_clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.tare_req) state_d = ACQ;
        ACQ:     if (bus.gross_valid && (cnt_q == LAST_CNT)) state_d = COMMIT;
        COMMIT:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore-style status outputs; a clear in the commit cycle suppresses the done pulse
  always_comb begin
    busy_o_c      = (state_q == ACQ);
    tare_done_o_c = (state_q == COMMIT) && !bus.tare_clr;
  end

  // Accumulator, sample counter and tare register next-state
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    tare_d = tare_q;
    if (bus.tare_clr) begin
      acc_d  = '0;
      cnt_d  = '0;
      tare_d = TARE_RST;
    end else begin
      case (state_q)
        IDLE: begin
          acc_d = '0;
          cnt_d = '0;
        end
        ACQ: begin
          if (bus.gross_valid) begin
            acc_d = acc_q + ACC_W'(bus.gross);
            cnt_d = cnt_q + 1'b1;
          end
        end
        COMMIT: begin
          tare_d = acc_q[AVG_LOG2 +: WIDTH];
        end
        default: begin
          acc_d = '0;
          cnt_d = '0;
        end
      endcase
    end
  end

  // Net path uses the tare held before this edge, so a commit only affects later samples
  always_comb begin
    net_d       = net_q;
    underflow_d = underflow_q;
    net_valid_d = 1'b0;
    if (bus.gross_valid) begin
      net_valid_d = 1'b1;
      if (bus.gross >= tare_q) begin
        net_d       = bus.gross - tare_q;
        underflow_d = 1'b0;
      end else begin
        net_d       = '0;
        underflow_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      tare_q      <= TARE_RST;
      net_q       <= '0;
      net_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      tare_q      <= tare_d;
      net_q       <= net_d;
      net_valid_q <= net_valid_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.tare      = tare_q;
  assign bus.net       = net_q;
  assign bus.net_valid = net_valid_q;
  assign bus.underflow = underflow_q;
  assign bus.busy      = busy_o_c;
  assign bus.tare_done = tare_done_o_c;

endmodule
